// File: rtl/tcam_mc_lookup_pkg.sv
// ----------------------------------------------------------------------------
// tcam_mc_lookup_pkg
// Shared definitions for the multi-channel TCAM lookup block:
//   - control FSM state encoding (idle / single-cycle write / clear-all sweep)
//   - default widths for the top-level parameters
//   - per-channel slice helper macros for the flattened channel buses
// No ports; imported with "import tcam_mc_lookup_pkg::*;".
// ----------------------------------------------------------------------------

// The slice macros expect DATA_WIDTH / ADDR_WIDTH to be visible where they are used.
`ifndef TCAM_MC_LOOKUP_SLICE_MACROS
`define TCAM_MC_LOOKUP_SLICE_MACROS
`define TCAM_CH_DATA(c) [(c)*DATA_WIDTH +: DATA_WIDTH]
`define TCAM_CH_ADDR(c) [(c)*ADDR_WIDTH +: ADDR_WIDTH]
`endif

package tcam_mc_lookup_pkg;

    localparam int unsigned TCAM_ADDR_WIDTH = 5;
    localparam int unsigned TCAM_DATA_WIDTH = 48;
    localparam int unsigned TCAM_NUM_CH     = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StSweep = 2'd2
    } tcam_state_e;

endpackage

// File: rtl/tcam_mc_lookup_prio_enc.sv
// ----------------------------------------------------------------------------
// tcam_prio_enc
// Lowest-index priority encoder over a TCAM hit vector.
// Ports:
//   hit          in  DEPTH       one bit per table entry, 1 = entry hit
//   match        out 1           at least one entry hit
//   multi_match  out 1           more than one entry hit
//   match_addr   out ADDR_WIDTH  index of the lowest hitting entry, 0 on miss
// ----------------------------------------------------------------------------
module tcam_prio_enc #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 32
) (
    input  logic [DEPTH-1:0]      hit,
    output logic                  match,
    output logic                  multi_match,
    output logic [ADDR_WIDTH-1:0] match_addr
);

    always_comb begin
        match       = 1'b0;
        multi_match = 1'b0;
        match_addr  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
                // Only the first hit seen (lowest index) sets the address.
                if (!match) begin
                    match_addr = ADDR_WIDTH'(i);
                end
                multi_match = multi_match | match;
                match       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcam_mc_lookup.sv
// ----------------------------------------------------------------------------
// tcam_mc_lookup
// Shared ternary table of DEPTH = 2**ADDR_WIDTH entries read by NUM_CH
// independent lookup channels. Each entry holds data, a stored compare mask
// and a valid bit. A small control FSM performs single-cycle entry writes or
// invalidates and a DEPTH-cycle clear-all sweep.
//
// Lookup: LKP_REQ in cycle N -> LKP_VLD with results in cycle N+2. The key is
// registered, compared against the table during cycle N+1, and the encoded
// result registered. Results are held until the channel's next LKP_VLD.
//
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   WR, INV, CLR_ALL       write / invalidate / clear-all requests (IDLE only)
//   ADDR_WR, DIN, DIN_MASK target entry, entry data, entry mask (1 = compare)
//   BUSY                   control FSM not idle
//   LKP_REQ, LKP_DIN, LKP_MASK           per-channel lookup strobe, key, mask
//   LKP_VLD, MATCH, MULTI_MATCH, MATCH_ADDR  per-channel results
// Optional (macro TCAM_RD_EN):
//   RD, ADDR_RD            entry readback request
//   DOUT, DOUT_MASK, DOUT_VALID, RD_ACK  readback data, one cycle after RD
// ----------------------------------------------------------------------------
module tcam_mc_lookup
    import tcam_mc_lookup_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = TCAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = TCAM_DATA_WIDTH,
    parameter int unsigned NUM_CH     = TCAM_NUM_CH
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         WR,
    input  logic                         INV,
    input  logic                         CLR_ALL,
    input  logic [ADDR_WIDTH-1:0]        ADDR_WR,
    input  logic [DATA_WIDTH-1:0]        DIN,
    input  logic [DATA_WIDTH-1:0]        DIN_MASK,
    output logic                         BUSY,
    input  logic [NUM_CH-1:0]            LKP_REQ,
    input  logic [NUM_CH*DATA_WIDTH-1:0] LKP_DIN,
    input  logic [NUM_CH*DATA_WIDTH-1:0] LKP_MASK,
    output logic [NUM_CH-1:0]            LKP_VLD,
    output logic [NUM_CH-1:0]            MATCH,
    output logic [NUM_CH-1:0]            MULTI_MATCH,
`ifdef TCAM_RD_EN
    input  logic                         RD,
    input  logic [ADDR_WIDTH-1:0]        ADDR_RD,
    output logic [DATA_WIDTH-1:0]        DOUT,
    output logic [DATA_WIDTH-1:0]        DOUT_MASK,
    output logic                         DOUT_VALID,
    output logic                         RD_ACK,
`endif
    output logic [NUM_CH*ADDR_WIDTH-1:0] MATCH_ADDR
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] mask_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    tcam_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] dmask_q, dmask_d;
    logic                  op_wr_q, op_wr_d;   // 1 = write entry, 0 = invalidate
    logic                  busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dmask_d = dmask_q;
        op_wr_d = op_wr_q;
        unique case (state_q)
            StIdle: begin
                if (CLR_ALL) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end else if (WR) begin
                    state_d = StWrite;
                    addr_d  = ADDR_WR;
                    din_d   = DIN;
                    dmask_d = DIN_MASK;
                    op_wr_d = 1'b1;
                end else if (INV) begin
                    state_d = StWrite;
                    addr_d  = ADDR_WR;
                    op_wr_d = 1'b0;
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            StSweep: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (&cnt_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            dmask_q <= '0;
            op_wr_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dmask_q <= dmask_d;
            op_wr_q <= op_wr_d;
            // Registered from the next state so BUSY lines up with the state itself.
            busy_q  <= (state_d != StIdle);
        end
    end

    assign BUSY = busy_q;

    // Valid bits: the only table state that is reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
        end else if (state_q == StWrite) begin
            valid_q[addr_q] <= op_wr_q;
        end else if (state_q == StSweep) begin
            valid_q[cnt_q] <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && state_q == StWrite && op_wr_q) begin
            data_q[addr_q] <= din_q;
            mask_q[addr_q] <= dmask_q;
        end
    end

    // ------------------------------------------------------------------
    // Lookup pipeline
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]            req_s1_q;
    logic [NUM_CH*DATA_WIDTH-1:0] key_s1_q;
    logic [NUM_CH*DATA_WIDTH-1:0] kmask_s1_q;
    logic [NUM_CH-1:0]            enc_match;
    logic [NUM_CH-1:0]            enc_multi;
    logic [NUM_CH*ADDR_WIDTH-1:0] enc_addr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            req_s1_q <= '0;
        end else begin
            req_s1_q <= LKP_REQ;
        end
    end

    always_ff @(posedge CLK) begin
        key_s1_q   <= LKP_DIN;
        kmask_s1_q <= LKP_MASK;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DEPTH-1:0] hit;

        // Compare runs against the table as it stands in the cycle after the request.
        always_comb begin
            hit = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hit[i] = valid_q[i] &&
                         (((data_q[i] ^ key_s1_q `TCAM_CH_DATA(c)) & mask_q[i] &
                           kmask_s1_q `TCAM_CH_DATA(c)) == '0);
            end
        end

        tcam_prio_enc #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH)
        ) u_prio_enc (
            .hit         (hit),
            .match       (enc_match[c]),
            .multi_match (enc_multi[c]),
            .match_addr  (enc_addr `TCAM_CH_ADDR(c))
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            LKP_VLD     <= '0;
            MATCH       <= '0;
            MULTI_MATCH <= '0;
            MATCH_ADDR  <= '0;
        end else begin
            LKP_VLD <= req_s1_q;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (req_s1_q[c]) begin
                    MATCH[c]                   <= enc_match[c];
                    MULTI_MATCH[c]             <= enc_multi[c];
                    MATCH_ADDR `TCAM_CH_ADDR(c) <= enc_addr `TCAM_CH_ADDR(c);
                end
            end
        end
    end

`ifdef TCAM_RD_EN
    // ------------------------------------------------------------------
    // Entry readback: only when nothing can touch the table this cycle.
    // ------------------------------------------------------------------
    logic rd_accept;

    assign rd_accept = RD && (state_q == StIdle) && !(WR || INV || CLR_ALL);

    always_ff @(posedge CLK) begin
        if (RST) begin
            RD_ACK     <= 1'b0;
            DOUT       <= '0;
            DOUT_MASK  <= '0;
            DOUT_VALID <= 1'b0;
        end else begin
            RD_ACK <= rd_accept;
            if (rd_accept) begin
                DOUT       <= data_q[ADDR_RD];
                DOUT_MASK  <= mask_q[ADDR_RD];
                DOUT_VALID <= valid_q[ADDR_RD];
            end
        end
    end
`endif

endmodule
